// File: rtl/seq_divider_if.sv
// Operand/result bundle between the Execute stage and the multi-cycle divider.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic               start;
  logic               signed_op;
  logic [WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]   divisor;
  logic               flush;
  logic               busy;
  logic               done;
  logic               div_by_zero;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   remainder;
  logic [2*WIDTH-1:0] result;

  modport master (
    output start, signed_op, dividend, divisor, flush,
    input  busy, done, div_by_zero, quotient, remainder, result
  );

  modport slave (
    input  start, signed_op, dividend, divisor, flush,
    output busy, done, div_by_zero, quotient, remainder, result
  );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring UDIV/SDIV unit for the Execute stage; reset is async active-low.
// Works on magnitudes and applies the sign correction in a final FIX cycle.
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  seq_divider_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_zero;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remd;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem_nx;

  // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits unsigned.
  always_comb begin
    w_a_neg = bus.signed_op & bus.dividend[WIDTH-1];
    w_b_neg = bus.signed_op & bus.divisor[WIDTH-1];
    w_a_mag = w_a_neg ? (-bus.dividend) : bus.dividend;
    w_b_mag = w_b_neg ? (-bus.divisor) : bus.divisor;
  end

  // One restoring step: shift next dividend bit in, keep the trial result if non-negative.
  always_comb begin
    w_rem_sh = {r_rem, r_q[WIDTH-1]};
    w_trial  = w_rem_sh - {1'b0, r_b};
    w_qbit   = ~w_trial[WIDTH];
    w_rem_nx = w_qbit ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_rem   <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_zero  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_quot  <= '0;
      r_remd  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start && !bus.flush) begin
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_b     <= w_b_mag;
            if (bus.divisor == '0) begin
              // Zero divide skips CALC; FIX turns |dividend| back into the dividend.
              r_zero  <= 1'b1;
              r_q     <= '0;
              r_rem   <= w_a_mag;
              r_cnt   <= '0;
              r_busy  <= 1'b0;
              r_state <= S_FIX;
            end else begin
              r_zero  <= 1'b0;
              r_q     <= w_a_mag;
              r_rem   <= '0;
              r_cnt   <= CW'(WIDTH);
              r_busy  <= 1'b1;
              r_state <= S_CALC;
            end
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          if (bus.flush) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_rem_nx;
            r_q   <= {r_q[WIDTH-2:0], w_qbit};
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
              r_state <= S_FIX;
            end
          end
        end
        S_FIX: begin
          r_busy <= 1'b0;
          if (bus.flush) begin
            r_state <= S_IDLE;
          end else begin
            r_quot  <= r_neg_q ? (-r_q) : r_q;
            r_remd  <= r_neg_r ? (-r_rem) : r_rem;
            r_dbz   <= r_zero;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_remd;
  assign bus.result      = {r_remd, r_quot};
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: latency, signed/unsigned results, zero divide,
// overflow, flush, back-to-back starts and mid-operation reset.
module tb_seq_divider;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   lat;
  int   bcnt;
  int   seen_done;

  seq_divider_if #(.WIDTH(32)) bus ();

  seq_divider #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge (T0), then wait (bounded) for done; lat = edges after T0.
  task automatic do_op(input logic sop, input logic [31:0] a, input logic [31:0] b,
                       output int o_lat, output int o_bcnt);
    bus.signed_op = sop;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    o_lat  = -1;
    o_bcnt = 0;
    for (int k = 0; k < 100; k++) begin
      if (bus.done) begin
        o_lat = k;
        break;
      end
      if (bus.busy) o_bcnt++;
      tick();
    end
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.flush     = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_dbz", 64'(bus.div_by_zero), 64'd0);
    chk("rst_result", bus.result, 64'd0);
    reset = 1'b1;
    tick();

    // UDIV 100/7
    do_op(1'b0, 32'd100, 32'd7, lat, bcnt);
    chk("udiv_lat", 64'(lat), 64'd33);
    chk("udiv_busy_cycles", 64'(bcnt), 64'd33);
    chk("udiv_q", 64'(bus.quotient), 64'd14);
    chk("udiv_r", 64'(bus.remainder), 64'd2);
    chk("udiv_result", bus.result, 64'h0000_0002_0000_000E);
    chk("udiv_dbz", 64'(bus.div_by_zero), 64'd0);
    tick();
    chk("udiv_done_1cyc", 64'(bus.done), 64'd0);
    chk("udiv_hold_q", 64'(bus.quotient), 64'd14);

    // SDIV sign handling
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
    chk("sdiv_m7_2_q", 64'(bus.quotient), 64'h0000_0000_FFFF_FFFD);
    chk("sdiv_m7_2_r", 64'(bus.remainder), 64'h0000_0000_FFFF_FFFF);
    tick();
    do_op(1'b1, 32'd7, 32'hFFFF_FFFE, lat, bcnt);
    chk("sdiv_7_m2_q", 64'(bus.quotient), 64'h0000_0000_FFFF_FFFD);
    chk("sdiv_7_m2_r", 64'(bus.remainder), 64'd1);
    tick();

    // Divide by zero
    do_op(1'b0, 32'd5, 32'd0, lat, bcnt);
    chk("dz_lat", 64'(lat), 64'd1);
    chk("dz_busy_cycles", 64'(bcnt), 64'd0);
    chk("dz_busy_now", 64'(bus.busy), 64'd0);
    chk("dz_q", 64'(bus.quotient), 64'd0);
    chk("dz_r", 64'(bus.remainder), 64'd5);
    chk("dz_flag", 64'(bus.div_by_zero), 64'd1);
    tick();
    do_op(1'b1, 32'hFFFF_FFF9, 32'd0, lat, bcnt);
    chk("sdz_r", 64'(bus.remainder), 64'h0000_0000_FFFF_FFF9);
    chk("sdz_flag", 64'(bus.div_by_zero), 64'd1);
    tick();

    // Signed overflow and unsigned max
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
    chk("ovf_q", 64'(bus.quotient), 64'h0000_0000_8000_0000);
    chk("ovf_r", 64'(bus.remainder), 64'd0);
    chk("ovf_dbz", 64'(bus.div_by_zero), 64'd0);
    tick();
    do_op(1'b0, 32'hFFFF_FFFF, 32'd1, lat, bcnt);
    chk("umax_q", 64'(bus.quotient), 64'h0000_0000_FFFF_FFFF);
    chk("umax_r", 64'(bus.remainder), 64'd0);
    tick();

    // Flush mid-operation: no done, outputs keep FFFFFFFF/0
    bus.signed_op = 1'b0;
    bus.dividend  = 32'd100;
    bus.divisor   = 32'd7;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_busy", 64'(bus.busy), 64'd0);
    seen_done = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done) seen_done++;
      tick();
    end
    chk("flush_no_done", 64'(seen_done), 64'd0);
    chk("flush_hold_result", bus.result, 64'h0000_0000_FFFF_FFFF);

    // Flush together with start: start ignored
    bus.dividend  = 32'd9;
    bus.divisor   = 32'd3;
    bus.start     = 1'b1;
    bus.flush     = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("flush_start_busy", 64'(bus.busy), 64'd0);
    tick();

    // Back-to-back: op B started in op A's DONE cycle
    do_op(1'b0, 32'd100, 32'd7, lat, bcnt);
    chk("b2b_a_lat", 64'(lat), 64'd33);
    chk("b2b_a_result", bus.result, 64'h0000_0002_0000_000E);
    do_op(1'b0, 32'd250, 32'd16, lat, bcnt);
    chk("b2b_b_lat", 64'(lat), 64'd33);
    chk("b2b_b_busy_cycles", 64'(bcnt), 64'd33);
    chk("b2b_b_result", bus.result, 64'h0000_000A_0000_000F);
    tick();

    // Reset during an operation
    bus.dividend = 32'd100;
    bus.divisor  = 32'd7;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (14) tick();
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_result", bus.result, 64'd0);
    chk("mid_rst_dbz", 64'(bus.div_by_zero), 64'd0);
    repeat (2) tick();
    chk("mid_rst_done", 64'(bus.done), 64'd0);
    reset = 1'b1;
    tick();
    do_op(1'b0, 32'd1000, 32'd10, lat, bcnt);
    chk("post_rst_lat", 64'(lat), 64'd33);
    chk("post_rst_q", 64'(bus.quotient), 64'd100);
    chk("post_rst_r", 64'(bus.remainder), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
